// File: rtl/truth_table_sweeper.sv
// Steps a combinational gate through every input vector, captures its response
// into a truth-table word and compares it against a golden table.
module truth_table_sweeper #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   expected,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic                   tt_valid,
    output logic [(1<<N_IN)-1:0]   truth_table,
    output logic                   match,
    output logic [N_IN-1:0]        first_miss
);

    localparam int TT_W  = 1 << N_IN;
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0]  V_LAST  = N_IN'(TT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_IN-1:0]     r_v;
    logic [CNT_W-1:0]    r_cnt;
    logic [TT_W-1:0]     r_tt;
    logic                r_miss;
    logic [N_IN-1:0]     r_first_miss;
    logic                r_match;
    logic                r_tt_valid;

    logic                w_start_acc;
    logic                w_sample;
    logic                w_miss_now;

    assign w_start_acc = (r_state != S_RUN) && start && !abort;
    assign w_sample    = (r_state == S_RUN) && !abort && (r_cnt == CNT_MAX);
    assign w_miss_now  = (dut_out != expected[r_v]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort)                            w_state_nxt = S_IDLE;
                else if (w_sample && (r_v == V_LAST)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // DONE lasts one cycle; a held start chains straight into the next sweep.
                if (w_start_acc) w_state_nxt = S_RUN;
                else             w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v          <= '0;
            r_cnt        <= '0;
            r_tt         <= '0;
            r_miss       <= 1'b0;
            r_first_miss <= '0;
            r_match      <= 1'b0;
            r_tt_valid   <= 1'b0;
        end else if (w_start_acc) begin
            r_v          <= '0;
            r_cnt        <= '0;
            r_tt         <= '0;
            r_miss       <= 1'b0;
            r_first_miss <= '0;
            r_match      <= 1'b0;
            r_tt_valid   <= 1'b0;
        end else if (abort) begin
            r_v        <= '0;
            r_cnt      <= '0;
            r_tt_valid <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_sample) begin
                r_tt[r_v] <= dut_out;
                if (w_miss_now && !r_miss) begin
                    r_first_miss <= r_v;
                    r_miss       <= 1'b1;
                end
                r_cnt <= '0;
                // The last vector wraps v back to 0, leaving the counters idle-clean.
                r_v   <= r_v + 1'b1;
                if (r_v == V_LAST) begin
                    r_tt_valid <= 1'b1;
                    r_match    <= !(r_miss || w_miss_now);
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign dut_in      = busy ? r_v : '0;
    assign tt_valid    = r_tt_valid;
    assign truth_table = r_tt;
    assign match       = r_match;
    assign first_miss  = r_first_miss;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a behavioural gate drives dut_out, a queue holds
// the expected table/match/first_miss of each sweep until its done pulse arrives.
module tb_truth_table_sweeper;

    localparam int N_IN = 3;
    localparam int TT_W = 8;
    localparam int SETTLE = 2;
    localparam int PERIOD = SETTLE + 1;

    typedef struct {
        logic [TT_W-1:0] tt;
        logic            m;
        logic [N_IN-1:0] fm;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [TT_W-1:0] expected = '0;
    logic [1:0]      gsel = 2'd0;
    logic            dut_out;
    logic [N_IN-1:0] dut_in;
    logic            busy, done, tt_valid, match;
    logic [TT_W-1:0] truth_table;
    logic [N_IN-1:0] first_miss;

    logic            start2 = 1'b0;
    logic            dut_out2;
    logic [N_IN-1:0] dut_in2;
    logic            busy2, done2, tt_valid2, match2;
    logic [TT_W-1:0] truth_table2;
    logic [N_IN-1:0] first_miss2;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    function automatic logic gate(input logic [1:0] sel, input logic [N_IN-1:0] v);
        case (sel)
            2'd0:    return (v == 3'd1) || (v == 3'd2) || (v == 3'd3);
            2'd1:    return (v == 3'd5) || (v == 3'd7);
            default: return v[0] ^ v[2];
        endcase
    endfunction

    function automatic exp_t model(input logic [1:0] sel, input logic [TT_W-1:0] exp_tbl);
        exp_t r;
        logic found;
        r.tt  = '0;
        r.fm  = '0;
        found = 1'b0;
        for (int v = 0; v < TT_W; v++) begin
            r.tt[v] = gate(sel, N_IN'(v));
            if (r.tt[v] != exp_tbl[v] && !found) begin
                r.fm  = N_IN'(v);
                found = 1'b1;
            end
        end
        r.m = !found;
        return r;
    endfunction

    assign dut_out  = gate(gsel, dut_in);
    assign dut_out2 = gate(gsel, dut_in2);

    truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(SETTLE)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done), .tt_valid(tt_valid),
        .truth_table(truth_table), .match(match), .first_miss(first_miss)
    );

    truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .expected(expected),
        .dut_out(dut_out2), .dut_in(dut_in2), .busy(busy2), .done(done2), .tt_valid(tt_valid2),
        .truth_table(truth_table2), .match(match2), .first_miss(first_miss2)
    );

    // Pulse start across one posedge (edge k); returns at the negedge after it.
    task automatic pulse_start(input logic push);
        if (push) q.push_back(model(gsel, expected));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Returns number of edges after edge k at which done is first seen.
    task automatic wait_done(input string name, output int edges);
        int n = 1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        edges = n - 1;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done never seen within %0d cycles, required done=1", name, n);
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        e = q.pop_front();
        checks++;
        if (truth_table !== e.tt) begin
            errors++;
            $display("FAIL %s truth_table: got %h expected %h", name, truth_table, e.tt);
        end
        checks++;
        if (match !== e.m) begin
            errors++;
            $display("FAIL %s match: got %b expected %b", name, match, e.m);
        end
        checks++;
        if (first_miss !== e.fm) begin
            errors++;
            $display("FAIL %s first_miss: got %0d expected %0d", name, first_miss, e.fm);
        end
        checks++;
        if (tt_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s tt_valid: got %b expected 1", name, tt_valid);
        end
    endtask

    task automatic full_sweep(input string name, input logic [1:0] sel, input logic [TT_W-1:0] tbl);
        int e;
        gsel     = sel;
        expected = tbl;
        pulse_start(1'b1);
        wait_done(name, e);
        checks++;
        if (e !== TT_W * PERIOD) begin
            errors++;
            $display("FAIL %s latency: done after %0d edges, expected %0d", name, e, TT_W * PERIOD);
        end
        check_result(name);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, tt_valid, match, dut_in, first_miss, truth_table} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b done=%b vld=%b match=%b in=%0d fm=%0d tt=%h expected all 0",
                     busy, done, tt_valid, match, dut_in, first_miss, truth_table);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_match;
        full_sweep("match_or123", 2'd0, 8'h0E);
        full_sweep("match_and3", 2'd1, 8'hA0);
    endtask

    task automatic test_mismatch;
        full_sweep("miss_first1", 2'd0, 8'hA0);
        full_sweep("miss_last7", 2'd0, 8'h8E);
        full_sweep("miss_first0", 2'd2, 8'hFF);
    endtask

    task automatic test_hold_and_abort_idle;
        logic [TT_W-1:0] saved;
        full_sweep("hold_pre", 2'd1, 8'hA1);
        saved = truth_table;
        repeat (5) @(negedge clk);
        checks++;
        if (tt_valid !== 1'b1 || truth_table !== saved || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold: got vld=%b tt=%h busy=%b expected vld=1 tt=%h busy=0",
                     tt_valid, truth_table, busy, saved);
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (tt_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got vld=%b busy=%b expected vld=0 busy=0", tt_valid, busy);
        end
    endtask

    task automatic test_dut_in_sequence;
        int n;
        int bad;
        gsel     = 2'd0;
        expected = 8'h0E;
        pulse_start(1'b1);
        bad = 0;
        for (n = 0; n < TT_W * PERIOD; n++) begin
            checks++;
            if (dut_in !== N_IN'(n / PERIOD) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL seq cycle %0d: got dut_in=%0d busy=%b done=%b expected dut_in=%0d busy=1 done=0",
                             n, dut_in, busy, done, n / PERIOD);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dut_in !== '0) begin
            errors++;
            $display("FAIL seq done: got done=%b busy=%b dut_in=%0d expected 1 0 0", done, busy, dut_in);
        end
        check_result("seq");
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL seq done_width: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_abort;
        int seen = 0;
        gsel     = 2'd0;
        expected = 8'h0E;
        pulse_start(1'b0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || dut_in !== '0 || tt_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_run: got busy=%b dut_in=%0d vld=%b expected 0 0 0", busy, dut_in, tt_valid);
        end
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_nodone: got %0d done cycles expected 0", seen);
        end
        full_sweep("after_abort", 2'd0, 8'h0E);
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        gsel     = 2'd1;
        expected = 8'h00;
        pulse_start(1'b0);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, tt_valid, match, dut_in, first_miss, truth_table} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b vld=%b match=%b in=%0d fm=%0d tt=%h expected all 0",
                     busy, done, tt_valid, match, dut_in, first_miss, truth_table);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_nodone: got %0d done cycles expected 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   n;
        int   dones = 0;
        gsel     = 2'd0;
        expected = 8'h8E;
        q.push_back(model(gsel, expected));
        q.push_back(model(gsel, expected));
        @(negedge clk) start2 = 1'b1;
        @(negedge clk);
        n = 1;
        while (dones < 2 && n < 100) begin
            if (done2) begin
                dones++;
                e = q.pop_front();
                checks++;
                if (n - 1 !== dones * (TT_W + 1) - 1) begin
                    errors++;
                    $display("FAIL b2b latency %0d: done at edge %0d expected %0d", dones, n - 1, dones * (TT_W + 1) - 1);
                end
                checks++;
                if (truth_table2 !== e.tt || match2 !== e.m || first_miss2 !== e.fm || tt_valid2 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b result %0d: got tt=%h m=%b fm=%0d vld=%b expected tt=%h m=%b fm=%0d vld=1",
                             dones, truth_table2, match2, first_miss2, tt_valid2, e.tt, e.m, e.fm);
                end
                if (dones == 2) start2 = 1'b0;
            end
            if (n - 1 == TT_W + 1) begin
                checks++;
                if (truth_table2 !== '0 || tt_valid2 !== 1'b0 || busy2 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b clear: got tt=%h vld=%b busy=%b expected tt=00 vld=0 busy=1",
                             truth_table2, tt_valid2, busy2);
                end
            end
            @(negedge clk);
            n++;
        end
        start2 = 1'b0;
        checks++;
        if (dones !== 2) begin
            errors++;
            $display("FAIL b2b count: got %0d done pulses expected 2", dones);
        end
        checks++;
        if (busy2 !== 1'b0) begin
            errors++;
            $display("FAIL b2b stop: got busy=%b expected 0", busy2);
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_hold_and_abort_idle();
        test_dut_in_sequence();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expected entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
